sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_mem.sv | 33 +++
 rtl/sync_fifo.sv | 117 +++++++++++
 tb/tb_sync_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and types for the sync_fifo block.
//   DefaultDataWidth   - default word width in bits
//   DefaultNumElements - default storage depth in words
//   fifo_flags_t       - bundle of the four occupancy status flags
package sync_fifo_pkg;

    localparam int unsigned DefaultDataWidth   = 32;
    localparam int unsigned DefaultNumElements = 16;

    typedef struct packed {
        logic pre_full;
        logic full;
        logic pre_empty;
        logic empty;
    } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port register array, one synchronous write port and
// one asynchronous read port. Contents are not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module sync_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and early-warning flags.
// Ports:
//   clk       - rising-edge clock
//   arst_n    - asynchronous active-low reset
//   wren      - write strobe, accepted when not full
//   wdata     - write data
//   pre_full  - occupancy == NUM_ELEMENTS-1
//   full      - occupancy == NUM_ELEMENTS
//   rden      - read strobe, accepted when not empty
//   rdata     - registered read data, holds until the next accepted read
//   pre_empty - occupancy == 1
//   empty     - occupancy == 0
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned NUM_ELEMENTS = DefaultNumElements
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  pre_full,
    output logic                  full,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  pre_empty,
    output logic                  empty
);

    localparam int unsigned PtrW = $clog2(NUM_ELEMENTS);
    localparam int unsigned CntW = $clog2(NUM_ELEMENTS + 1);

    localparam logic [PtrW-1:0] PtrLast  = PtrW'(NUM_ELEMENTS - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(NUM_ELEMENTS);
    localparam logic [CntW-1:0] CntAlmost = CntW'(NUM_ELEMENTS - 1);

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc, rd_acc;
    fifo_flags_t           flags;

    // Flags come from registered count only, so they never depend on the strobes.
    always_comb begin
        flags           = '0;
        flags.full      = (count_q == CntFull);
        flags.pre_full  = (count_q == CntAlmost);
        flags.empty     = (count_q == '0);
        flags.pre_empty = (count_q == CntW'(1));
    end

    assign full      = flags.full;
    assign pre_full  = flags.pre_full;
    assign empty     = flags.empty;
    assign pre_empty = flags.pre_empty;
    assign rdata     = rdata_q;

    // Acceptance uses the pre-edge flags: a write to a full FIFO is dropped even
    // if a read frees a slot in the same cycle.
    assign wr_acc = wren && !flags.full;
    assign rd_acc = rden && !flags.empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;

        // Explicit wrap so non-power-of-two depths work.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
            rdata_d  = mem_rdata;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
        end
    end

    // Same-address read/write cannot both be accepted: equal pointers mean the
    // FIFO is empty (read blocked) or full (write blocked).
    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_ELEMENTS),
        .ADDR_WIDTH (PtrW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo using a queue-based reference.
module tb_sync_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 16;

    logic          clk;
    logic          arst_n;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          pre_full;
    logic          full;
    logic          rden;
    logic [DW-1:0] rdata;
    logic          pre_empty;
    logic          empty;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference: contents as a queue, plus the last word popped.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_rdata;

    sync_fifo #(
        .DATA_WIDTH   (DW),
        .NUM_ELEMENTS (N)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .wren      (wren),
        .wdata     (wdata),
        .pre_full  (pre_full),
        .full      (full),
        .rden      (rden),
        .rdata     (rdata),
        .pre_empty (pre_empty),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected flags {pre_full, full, pre_empty, empty} from occupancy alone.
    function automatic logic [DW-1:0] exp_flags(input int unsigned occ);
        logic [3:0] f;
        f[3] = (occ == N - 1);
        f[2] = (occ == N);
        f[1] = (occ == 1);
        f[0] = (occ == 0);
        return DW'(f);
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, "_flags"}, DW'({pre_full, full, pre_empty, empty}),
                 exp_flags(model_q.size()));
        check_eq({tag, "_rdata"}, rdata, model_rdata);
    endtask

    // One clock with the given strobes; model advances at the edge, outputs checked 1 ns later.
    task automatic do_cycle(input logic w, input logic [DW-1:0] d, input logic r,
                            input string tag);
        bit wa, ra;
        wren  = w;
        wdata = d;
        rden  = r;
        wa = w && (model_q.size() < N);
        ra = r && (model_q.size() > 0);
        @(posedge clk);
        if (ra) model_rdata = model_q.pop_front();
        if (wa) model_q.push_back(d);
        #1;
        wren = 1'b0;
        rden = 1'b0;
        check_state(tag);
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        #50;
        model_q.delete();
        model_rdata = '0;
        check_state("reset");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        wren        = 1'b0;
        rden        = 1'b0;
        wdata       = '0;
        arst_n      = 1'b1;
        model_rdata = '0;

        apply_reset();

        // Fill 0x1..0x10, then a dropped write of 0xDEAD.
        for (int i = 1; i <= 16; i++) do_cycle(1'b1, DW'(i), 1'b0, "fill");
        check_eq("full_after_16", DW'(full), DW'(1));
        do_cycle(1'b1, 32'hDEAD, 1'b0, "overflow");
        check_eq("full_after_drop", DW'(full), DW'(1));

        // Drain in order, then a dropped read keeps 0x10.
        for (int i = 1; i <= 16; i++) begin
            do_cycle(1'b0, '0, 1'b1, "drain");
            check_eq("drain_order", rdata, DW'(i));
        end
        check_eq("empty_after_drain", DW'(empty), DW'(1));
        do_cycle(1'b0, '0, 1'b1, "underflow");
        check_eq("rdata_hold", rdata, 32'h10);

        // Write to empty with read strobe: no bypass.
        do_cycle(1'b1, 32'h55, 1'b1, "no_bypass");
        check_eq("no_bypass_rdata", rdata, 32'h10);
        do_cycle(1'b0, '0, 1'b1, "pop_bypass");

        // Count 5, then 20 cycles of simultaneous traffic across the wrap.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, DW'(32'h100 + i), 1'b0, "pre5");
        for (int i = 0; i < 20; i++) do_cycle(1'b1, DW'(32'h200 + i), 1'b1, "simul");
        check_eq("simul_flags", DW'({pre_full, full, pre_empty, empty}), DW'(0));

        // Fill up, then both strobes while full: read taken, write dropped.
        while (model_q.size() < N) do_cycle(1'b1, $urandom, 1'b0, "refill");
        do_cycle(1'b1, 32'hBEEF, 1'b1, "full_both");
        check_eq("full_both_prefull", DW'(pre_full), DW'(1));
        for (int i = 0; i < 15; i++) do_cycle(1'b0, '0, 1'b1, "drain2");
        check_eq("drain2_empty", DW'(empty), DW'(1));

        // Random traffic with shifting write/read bias.
        for (int blk = 0; blk < 20; blk++) begin
            int unsigned pw, pr;
            pw = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int i = 0; i < 1000; i++) begin
                do_cycle(($urandom_range(99, 0) < pw), $urandom,
                         ($urandom_range(99, 0) < pr), "rand");
            end
        end

        // Mid-operation reset: contents discarded before any clock edge.
        while (model_q.size() < 3) do_cycle(1'b1, $urandom, 1'b0, "pre_rst");
        do_cycle(1'b0, '0, 1'b1, "pre_rst_rd");
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_eq("async_rst_empty", DW'(empty), DW'(1));
        check_eq("async_rst_rdata", rdata, '0);
        apply_reset();
        do_cycle(1'b1, 32'hA5A5, 1'b0, "post_rst_wr");
        do_cycle(1'b0, '0, 1'b1, "post_rst_rd");
        check_eq("post_rst_data", rdata, 32'hA5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
